btn_press_gen: RTL and testbench
================================

Name: btn_press_gen

Overview:
- Synthesizable button-press stimulus generator: the transmit side of the push-button interface in UnidadDeControl.
- Replays scripted press patterns on a virtual button line: N short taps, optionally followed by one long hold.
- Output `botonTest` drives the button-detector input directly.
- Used for the on-board demo/self-test mode and as a reusable stimulus source in block benches.

Parameters:
- TICK_DIV, 1: clocks per timing tick (prescaler divisor, >=1).
- TAP_TICKS, 1: ticks `botonTest` stays high for one tap (>=1).
- GAP_TICKS, 1: ticks low between consecutive presses (>=1).
- HOLD_TICKS, 11: ticks high for the long press (>=1).
- SETTLE_TICKS, 3: ticks low after the last press before completion (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled on rising clk edge, accepted only in IDLE
- num_taps  in  4  number of short taps, 0..15; latched on accept
- long_press  in  1  append one long hold after the taps; latched on accept
- abort  in  1  cancel the pattern in progress
- botonTest  out  1  generated virtual button level, registered
- busy  out  1  pattern in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: rst low asynchronously forces state IDLE, all counters 0, and botonTest=0, busy=0, done=0.
- Tick prescaler:
  - Cleared on accept; produces one tick every TICK_DIV clocks.
  - Each phase of P ticks therefore lasts exactly P*TICK_DIV clocks.
- States: IDLE, TAP_HI, TAP_LO, HOLD_HI, SETTLE.
- Accept:
  - Occurs when start=1 in IDLE.
  - num_taps and long_press are latched.
  - From the next cycle, busy=1 and the first phase begins.
  - The first phase is TAP_HI if num_taps>0, else HOLD_HI if long_press=1.
- Empty request (num_taps=0, long_press=0):
  - No waveform; busy stays 0.
  - done=1 in the cycle after accept.
- TAP_HI: botonTest=1 for TAP_TICKS. Then:
  - more taps remain -> TAP_LO;
  - last tap and long_press -> TAP_LO, then HOLD_HI;
  - otherwise -> SETTLE.
- TAP_LO: botonTest=0 for GAP_TICKS. Then next TAP_HI, or HOLD_HI after the last tap.
- HOLD_HI: botonTest=1 for HOLD_TICKS, then SETTLE.
- SETTLE: botonTest=0 for SETTLE_TICKS, then IDLE.
  - busy falls and done=1 for exactly one cycle, on the same edge.
- Busy duration in clocks:
  - TICK_DIV * (n*TAP_TICKS + (n-1)*GAP_TICKS + L*((n>0)*GAP_TICKS + HOLD_TICKS) + SETTLE_TICKS)
  - n = num_taps, L = long_press; the (n-1) gap term is 0 when n=0.
- start while busy: ignored, with no queueing; latched values are unchanged.
- abort=1 while busy:
  - Next cycle: IDLE, botonTest=0, busy=0.
  - done is not asserted.
- abort and start in the same IDLE cycle: abort wins, request dropped.
- abort in IDLE: no effect.
- Counter widths:
  - Tap counter is 4 bits, counting down from the latched num_taps, with no wrap.
  - Phase counter width covers max(TAP_TICKS, GAP_TICKS, HOLD_TICKS, SETTLE_TICKS).
  - Prescaler width covers TICK_DIV.
- Glitch-free: botonTest comes straight from a flop; no combinational path from inputs to outputs.

Decomposition:
- Shared package `btn_pkg`: state encoding localparams (IDLE, TAP_HI, TAP_LO, HOLD_HI, SETTLE) and a counter-width function, reused by the button detector and its benches.
- Sub-module `btn_tick_gen`: prescaler with TICK_DIV parameter, synchronous clear input and one-cycle tick output.

Test Plan (defaults, TICK_DIV=1, unless stated):
- num_taps=3, long_press=0, one-cycle start -> botonTest H,L,H,L,H,L,L,L; busy 8 cycles; done 1 cycle on the busy falling edge.
- num_taps=0, long_press=1 -> botonTest high 11 cycles then low 3; busy 14; one done pulse.
- num_taps=3, long_press=1 -> H,L,H,L,H,L, then 11 H, then 3 L; busy 20; one done pulse.
- num_taps=0, long_press=0 -> busy never 1, botonTest stays 0, done=1 exactly one cycle after accept.
- Second start mid-pattern is ignored (total busy still 8). abort at cycle 5 of a hold -> botonTest=0 and busy=0 next cycle, no done. A new start afterwards is accepted normally.
- TICK_DIV=4, num_taps=1, long_press=0 -> high 4 clocks, low 12, busy 16.
  - Separately: rst pulled low mid-tap -> botonTest/busy drop to 0 without waiting for a clk edge; IDLE after release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button stimulus generator and detector:
// phase encoding and a helper that sizes down-counters.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAP_HI,
        TAP_LO,
        HOLD_HI,
        SETTLE
    } btn_state_e;

    // Bits needed to hold any value 0..max_val (never less than one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// Timing prescaler: one-cycle tick on the last clock of every TICK_DIV-clock
// period, restarted from zero by a synchronous clear.
module btn_tick_gen
    import btn_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int W = cnt_width(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_press_gen.sv
// Scripted button-press generator: replays N short taps plus an optional long
// hold on a registered virtual button line, then settles low and pulses done.
module btn_press_gen
    import btn_pkg::*;
#(
    parameter int TICK_DIV     = 1,
    parameter int TAP_TICKS    = 1,
    parameter int GAP_TICKS    = 1,
    parameter int HOLD_TICKS   = 11,
    parameter int SETTLE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] num_taps,
    input  logic       long_press,
    input  logic       abort,
    output logic       botonTest,
    output logic       busy,
    output logic       done
);

    localparam int PMAX_A = (TAP_TICKS > GAP_TICKS) ? TAP_TICKS : GAP_TICKS;
    localparam int PMAX_B = (HOLD_TICKS > SETTLE_TICKS) ? HOLD_TICKS : SETTLE_TICKS;
    localparam int PMAX   = (PMAX_A > PMAX_B) ? PMAX_A : PMAX_B;
    localparam int PW     = cnt_width(PMAX);

    // Phase counter is loaded with length-1 and expires after it reads zero on a tick
    localparam logic [PW-1:0] TAP_LD    = PW'(TAP_TICKS - 1);
    localparam logic [PW-1:0] GAP_LD    = PW'(GAP_TICKS - 1);
    localparam logic [PW-1:0] HOLD_LD   = PW'(HOLD_TICKS - 1);
    localparam logic [PW-1:0] SETTLE_LD = PW'(SETTLE_TICKS - 1);

    btn_state_e    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    taps_q, taps_d;
    logic          long_q, long_d;
    logic          boton_q, boton_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    taps_dec;
    logic          tick;

    // Prescaler held at zero while idle so every pattern starts on a fresh tick period
    btn_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        taps_d   = taps_q;
        long_d   = long_q;
        done_d   = 1'b0;
        taps_dec = (taps_q != 4'd0) ? (taps_q - 4'd1) : 4'd0;

        if (state_q == IDLE) begin
            if (start && !abort) begin
                taps_d = num_taps;
                long_d = long_press;
                if (num_taps != 4'd0) begin
                    state_d = TAP_HI;
                    phase_d = TAP_LD;
                end else if (long_press) begin
                    state_d = HOLD_HI;
                    phase_d = HOLD_LD;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (abort) begin
            state_d = IDLE;
            phase_d = '0;
            taps_d  = 4'd0;
        end else if (tick) begin
            if (phase_q != '0) begin
                phase_d = phase_q - PW'(1);
            end else begin
                case (state_q)
                    TAP_HI: begin
                        taps_d = taps_dec;
                        if (taps_dec != 4'd0 || long_q) begin
                            state_d = TAP_LO;
                            phase_d = GAP_LD;
                        end else begin
                            state_d = SETTLE;
                            phase_d = SETTLE_LD;
                        end
                    end
                    TAP_LO: begin
                        if (taps_q != 4'd0) begin
                            state_d = TAP_HI;
                            phase_d = TAP_LD;
                        end else begin
                            state_d = HOLD_HI;
                            phase_d = HOLD_LD;
                        end
                    end
                    HOLD_HI: begin
                        state_d = SETTLE;
                        phase_d = SETTLE_LD;
                    end
                    SETTLE: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        boton_d = (state_d == TAP_HI) || (state_d == HOLD_HI);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            taps_q  <= 4'd0;
            long_q  <= 1'b0;
            boton_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            taps_q  <= taps_d;
            long_q  <= long_d;
            boton_q <= boton_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign botonTest = boton_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_btn_press_gen.sv
// Bench for btn_press_gen: waveform-list model checked every cycle on the
// default instance, plus literal waveform checks on both instances.
module tb_btn_press_gen;

    localparam int MDIV = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] num_taps = 4'd0;
    logic       long_press = 1'b0;
    logic       abort = 1'b0;
    logic       botonTest, busy, done;
    logic       botonTest4, busy4, done4;

    int checks = 0;
    int errors = 0;

    btn_press_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_taps   (num_taps),
        .long_press (long_press),
        .abort      (abort),
        .botonTest  (botonTest),
        .busy       (busy),
        .done       (done)
    );

    btn_press_gen #(.TICK_DIV(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_taps   (num_taps),
        .long_press (long_press),
        .abort      (abort),
        .botonTest  (botonTest4),
        .busy       (busy4),
        .done       (done4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: an accepted request expands into the list of button levels for each busy cycle
    bit wave[$];
    bit m_boton = 1'b0;
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;

    task automatic pushLevel(input bit lvl, input int ticks);
        for (int i = 0; i < ticks * MDIV; i++) wave.push_back(lvl);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wave.delete();
            m_boton = 1'b0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy && abort) begin
                wave.delete();
                m_busy  = 1'b0;
                m_boton = 1'b0;
            end else if (!m_busy) begin
                if (start && !abort) begin
                    for (int t = 0; t < int'(num_taps); t++) begin
                        if (t > 0) pushLevel(1'b0, 1);
                        pushLevel(1'b1, 1);
                    end
                    if (long_press) begin
                        if (num_taps != 4'd0) pushLevel(1'b0, 1);
                        pushLevel(1'b1, 11);
                    end
                    if (wave.size() == 0) begin
                        m_done = 1'b1;
                    end else begin
                        pushLevel(1'b0, 3);
                        m_boton = wave.pop_front();
                        m_busy  = 1'b1;
                    end
                end
            end else if (wave.size() == 0) begin
                m_busy  = 1'b0;
                m_boton = 1'b0;
                m_done  = 1'b1;
            end else begin
                m_boton = wave.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("model_boton", int'(botonTest), int'(m_boton));
            checkOutput("model_busy", int'(busy), int'(m_busy));
            checkOutput("model_done", int'(done), int'(m_done));
        end
    end

    // One-cycle start, then record the chosen instance's outputs from the first phase cycle on
    task automatic applyStimulus(input int n, input bit l, input int cycles, input bit sel,
                                 output logic [31:0] wv, output int busyCnt,
                                 output int doneCnt, output int doneIdx);
        @(negedge clk);
        start = 1'b1;
        num_taps = 4'(n);
        long_press = l;
        @(negedge clk);
        start = 1'b0;
        wv = '0;
        busyCnt = 0;
        doneCnt = 0;
        doneIdx = -1;
        for (int i = 0; i < cycles; i++) begin
            wv = {wv[30:0], sel ? botonTest4 : botonTest};
            busyCnt += int'(sel ? busy4 : busy);
            if (sel ? done4 : done) begin
                doneCnt++;
                if (doneIdx < 0) doneIdx = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic waitIdle(input int limit);
        int k = 0;
        while ((busy || busy4) && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (busy || busy4) checkOutput("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got 1 expected 0");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] wv;
        int bc, dc, di;

        #3;
        checkOutput("rst_boton", int'(botonTest), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        #20 rst = 1'b1;

        applyStimulus(3, 1'b0, 10, 1'b0, wv, bc, dc, di);
        checkOutput("t3_wave", int'(wv[9:0]), int'(10'b1010100000));
        checkOutput("t3_busy", bc, 8);
        checkOutput("t3_done_cnt", dc, 1);
        checkOutput("t3_done_idx", di, 8);
        waitIdle(200);

        applyStimulus(0, 1'b1, 16, 1'b0, wv, bc, dc, di);
        checkOutput("hold_wave", int'(wv[15:0]), int'(16'b1111111111100000));
        checkOutput("hold_busy", bc, 14);
        checkOutput("hold_done_cnt", dc, 1);
        waitIdle(200);

        applyStimulus(3, 1'b1, 22, 1'b0, wv, bc, dc, di);
        checkOutput("t3h_wave", int'(wv[21:0]), int'({6'b101010, 11'h7FF, 5'b00000}));
        checkOutput("t3h_busy", bc, 20);
        checkOutput("t3h_done_cnt", dc, 1);
        checkOutput("t3h_done_idx", di, 20);
        waitIdle(200);

        applyStimulus(0, 1'b0, 4, 1'b0, wv, bc, dc, di);
        checkOutput("empty_wave", int'(wv[3:0]), 0);
        checkOutput("empty_busy", bc, 0);
        checkOutput("empty_done_cnt", dc, 1);
        checkOutput("empty_done_idx", di, 0);
        waitIdle(200);

        // Second start mid-pattern must not extend or replace the running pattern
        @(negedge clk);
        start = 1'b1;
        num_taps = 4'd3;
        long_press = 1'b0;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            bc += int'(busy);
            start = (i == 3);
            num_taps = (i == 3) ? 4'd1 : 4'd3;
            long_press = (i == 3);
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("restart_busy", bc, 8);
        waitIdle(200);

        // Abort in the fifth cycle of a hold
        @(negedge clk);
        start = 1'b1;
        num_taps = 4'd0;
        long_press = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_pre_boton", int'(botonTest), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_boton", int'(botonTest), 0);
        checkOutput("abort_busy", int'(busy), 0);
        dc = 0;
        for (int i = 0; i < 16; i++) begin
            dc += int'(done);
            @(negedge clk);
        end
        checkOutput("abort_no_done", dc, 0);
        waitIdle(200);

        applyStimulus(1, 1'b0, 6, 1'b0, wv, bc, dc, di);
        checkOutput("post_abort_wave", int'(wv[5:0]), int'(6'b100000));
        checkOutput("post_abort_busy", bc, 4);
        checkOutput("post_abort_done", dc, 1);
        waitIdle(200);

        // Abort together with start while idle drops the request
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        num_taps = 4'd2;
        long_press = 1'b0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_busy", int'(busy), 0);
        checkOutput("abort_start_done", int'(done), 0);
        waitIdle(200);

        applyStimulus(1, 1'b0, 20, 1'b1, wv, bc, dc, di);
        checkOutput("div4_wave", int'(wv[19:0]), int'(20'hF0000));
        checkOutput("div4_busy", bc, 16);
        checkOutput("div4_done_idx", di, 16);
        waitIdle(200);

        // Asynchronous reset in the middle of a tap on the divided instance
        @(negedge clk);
        start = 1'b1;
        num_taps = 4'd2;
        long_press = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("div4_pre_rst_boton", int'(botonTest4), 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_boton", int'(botonTest4), 0);
        checkOutput("async_rst_busy", int'(busy4), 0);
        @(negedge clk);
        rst = 1'b1;
        bc = 0;
        for (int i = 0; i < 6; i++) begin
            bc += int'(busy4) + int'(botonTest4);
            @(negedge clk);
        end
        checkOutput("post_rst_idle", bc, 0);

        applyStimulus(1, 1'b0, 20, 1'b1, wv, bc, dc, di);
        checkOutput("post_rst_div4_busy", bc, 16);
        waitIdle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
